rca2_ora: RTL and testbench

Output response analyzer for the 4-bit ripple-carry adder double-fault test setup. It observes the pattern applied to the adder under test (`at`, `bt`, `cint`) and the adder's response (`sum`, `cout`) in the same cycle. It computes the golden result internally and flags mismatches. Over one full 8-pattern test session it accumulates the error count, a per-output error mask, the index of the first failing pattern and an 8-bit MISR signature, then reports pass/fail.

---
 rtl/rca2_ora_if.sv | 27 ++
 rtl/rca2_ora.sv | 123 ++++++++++++
 tb/tb_rca2_ora.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/rca2_ora_if.sv
// Bundles the adder-under-test stimulus/response and analyzer results for rca2_ora.
interface rca2_ora_if;
  logic       test;
  logic [3:0] at;
  logic [3:0] bt;
  logic       cint;
  logic [3:0] sum;
  logic       cout;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_cnt;
  logic [4:0] err_mask;
  logic [2:0] first_fail;
  logic       fail_seen;
  logic [7:0] signature;

  modport slave (
    input  test, at, bt, cint, sum, cout,
    output busy, done, pass, err_cnt, err_mask, first_fail, fail_seen, signature
  );

  modport master (
    output test, at, bt, cint, sum, cout,
    input  busy, done, pass, err_cnt, err_mask, first_fail, fail_seen, signature
  );
endinterface

// File: rtl/rca2_ora.sv
// Output response analyzer for the 4-bit ripple-carry adder test session:
// golden compare, error statistics and an 8-bit MISR over 8 patterns.
module rca2_ora (
  input logic         clk,
  input logic         init_n,
  rca2_ora_if.slave   bus
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned RSP_W = 5;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned SIG_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_n;
  logic [RSP_W-1:0]   err_mask_q, err_mask_n;
  logic [IDX_W-1:0]   first_fail_q, first_fail_n;
  logic               fail_seen_q, fail_seen_n;
  logic [SIG_W-1:0]   sig_q, sig_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;
  logic               pass_q, pass_n;

  logic [RSP_W-1:0]   exp_rsp;
  logic [RSP_W-1:0]   diff;
  logic               mism;
  logic [SIG_W-1:0]   sh;
  logic [SIG_W-1:0]   sig_upd;

  // Golden add and MISR step for the current sample
  always_comb begin
    exp_rsp = RSP_W'(bus.at) + RSP_W'(bus.bt) + RSP_W'(bus.cint);
    diff    = exp_rsp ^ {bus.cout, bus.sum};
    mism    = |diff;
    sh      = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? 8'h1D : 8'h00);
    sig_upd = sh ^ {3'b000, bus.cout, bus.sum};
  end

  // Next-state and result update
  always_comb begin
    state_n      = state_q;
    idx_n        = idx_q;
    err_cnt_n    = err_cnt_q;
    err_mask_n   = err_mask_q;
    first_fail_n = first_fail_q;
    fail_seen_n  = fail_seen_q;
    sig_n        = sig_q;

    case (state_q)
      IDLE: begin
        if (bus.test) begin
          state_n      = RUN;
          idx_n        = '0;
          err_cnt_n    = '0;
          err_mask_n   = '0;
          first_fail_n = '0;
          fail_seen_n  = 1'b0;
          sig_n        = '0;
        end
      end
      RUN: begin
        if (bus.test) begin
          idx_n      = idx_q + IDX_W'(1);
          err_cnt_n  = err_cnt_q + CNT_W'(mism);
          err_mask_n = err_mask_q | diff;
          sig_n      = sig_upd;
          if (!fail_seen_q && mism) begin
            first_fail_n = idx_q;
            fail_seen_n  = 1'b1;
          end
          if (idx_q == IDX_W'(7)) state_n = DONE;
        end
      end
      DONE: begin
        if (!bus.test) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == RUN);
    done_n = (state_n == DONE);
    pass_n = done_n && (err_cnt_n == '0);
  end

  always_ff @(posedge clk) begin
    if (!init_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      err_cnt_q    <= '0;
      err_mask_q   <= '0;
      first_fail_q <= '0;
      fail_seen_q  <= 1'b0;
      sig_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_n;
      idx_q        <= idx_n;
      err_cnt_q    <= err_cnt_n;
      err_mask_q   <= err_mask_n;
      first_fail_q <= first_fail_n;
      fail_seen_q  <= fail_seen_n;
      sig_q        <= sig_n;
      busy_q       <= busy_n;
      done_q       <= done_n;
      pass_q       <= pass_n;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.err_mask   = err_mask_q;
  assign bus.first_fail = first_fail_q;
  assign bus.fail_seen  = fail_seen_q;
  assign bus.signature  = sig_q;

endmodule

// File: tb/tb_rca2_ora.sv
// Directed bench for rca2_ora: faulty-adder model drives sessions, expected
// session results are queued at stimulus time and compared when done appears.
module tb_rca2_ora;

  typedef struct packed {
    logic       pass;
    logic [3:0] cnt;
    logic [4:0] mask;
    logic [2:0] ff;
    logic       fs;
    logic [7:0] sig;
  } res_t;

  logic clk = 1'b0;
  logic init_n;
  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];

  logic [3:0] pat_a [8];
  logic [3:0] pat_b [8];
  logic       pat_c [8];

  // bench-side running model
  logic [3:0] m_cnt;
  logic [4:0] m_mask;
  logic [2:0] m_ff;
  logic       m_fs;
  logic [7:0] m_sig;
  logic [7:0] clean_sig;
  int         edges;

  rca2_ora_if bus ();

  rca2_ora dut (
    .clk    (clk),
    .init_n (init_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  // Adder under test: 0 ideal, 1 sum[1] sa0, 2 cout sa0 + sum[3] sa1, 3 cout sa0
  function automatic logic [4:0] adder(input logic [3:0] a, input logic [3:0] b,
                                       input logic c, input int fault);
    logic [4:0] r;
    r = {1'b0, a} + {1'b0, b} + {4'b0, c};
    case (fault)
      1: r[1] = 1'b0;
      2: begin r[4] = 1'b0; r[3] = 1'b1; end
      3: r[4] = 1'b0;
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] misr(input logic [7:0] s, input logic [4:0] rsp);
    logic [7:0] sh;
    sh = {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00);
    return sh ^ {3'b000, rsp};
  endfunction

  task automatic apply(input int i, input int fault);
    logic [4:0] r;
    logic [4:0] g;
    r = adder(pat_a[i], pat_b[i], pat_c[i], fault);
    g = adder(pat_a[i], pat_b[i], pat_c[i], 0);
    bus.at = pat_a[i]; bus.bt = pat_b[i]; bus.cint = pat_c[i];
    bus.sum = r[3:0]; bus.cout = r[4];
    if (r != g) begin
      m_cnt = m_cnt + 4'd1;
      if (!m_fs) begin m_ff = 3'(i); m_fs = 1'b1; end
    end
    m_mask = m_mask | (r ^ g);
    m_sig  = misr(m_sig, r);
  endtask

  // Runs a session; pause_len > 0 drops test after pattern 3, abort_after >= 0 resets.
  task automatic session(input int fault, input int pause_len, input int abort_after,
                         output res_t got);
    res_t e;
    m_cnt = 0; m_mask = 0; m_ff = 0; m_fs = 0; m_sig = 0;
    edges = 0;
    bus.test = 1'b1;
    apply(0, 0);
    m_cnt = 0; m_mask = 0; m_ff = 0; m_fs = 0; m_sig = 0;
    step();
    chk("enter_busy", 32'(bus.busy), 32'd1);
    chk("enter_clear", 32'({bus.err_cnt, bus.err_mask, bus.fail_seen, bus.signature}), 32'd0);
    for (int i = 0; i < 8; i++) begin
      apply(i, fault);
      if (i == 7) begin
        e = '{pass: (m_cnt == 0), cnt: m_cnt, mask: m_mask, ff: m_ff, fs: m_fs, sig: m_sig};
        exp_q.push_back(e);
      end
      step();
      chk("run_cnt", 32'(bus.err_cnt), 32'(m_cnt));
      chk("run_sig", 32'(bus.signature), 32'(m_sig));
      if (i < 7) chk("run_busy", 32'({bus.busy, bus.done}), 32'b10);
      if (i == abort_after) begin
        chk("pre_abort_cnt", 32'(bus.err_cnt), 32'd2);
        init_n = 1'b0;
        step();
        chk("abort_clear", 32'({bus.busy, bus.done, bus.pass, bus.err_cnt, bus.err_mask,
                                bus.first_fail, bus.fail_seen, bus.signature}), 32'd0);
        init_n = 1'b1;
        bus.test = 1'b0;
        step();
        got = '0;
        return;
      end
      if (i == 3 && pause_len > 0) begin
        bus.test = 1'b0;
        for (int p = 0; p < pause_len; p++) begin
          step();
          chk("pause_busy", 32'(bus.busy), 32'd1);
          chk("pause_hold", 32'({bus.err_cnt, bus.err_mask, bus.fail_seen, bus.signature}),
              32'({m_cnt, m_mask, m_fs, m_sig}));
        end
        bus.test = 1'b1;
      end
    end
    chk("done_edge", edges, 32'(9 + pause_len));
    chk("done_flags", 32'({bus.busy, bus.done}), 32'b01);
    e = exp_q.pop_front();
    got = '{pass: bus.pass, cnt: bus.err_cnt, mask: bus.err_mask, ff: bus.first_fail,
            fs: bus.fail_seen, sig: bus.signature};
    chk("sess_pass", 32'(got.pass), 32'(e.pass));
    chk("sess_cnt", 32'(got.cnt), 32'(e.cnt));
    chk("sess_mask", 32'(got.mask), 32'(e.mask));
    chk("sess_fs", 32'(got.fs), 32'(e.fs));
    if (e.fs) chk("sess_ff", 32'(got.ff), 32'(e.ff));
    chk("sess_sig", 32'(got.sig), 32'(e.sig));
    // test still high: stay in DONE, results frozen
    apply(1, fault);
    step();
    chk("done_hold", 32'({bus.done, bus.pass, bus.err_cnt, bus.signature}),
        32'({1'b1, e.pass, e.cnt, e.sig}));
    bus.test = 1'b0;
    step();
    chk("exit_flags", 32'({bus.busy, bus.done, bus.pass}), 32'd0);
    chk("exit_hold", 32'({bus.err_cnt, bus.err_mask, bus.fail_seen, bus.signature}),
        32'({e.cnt, e.mask, e.fs, e.sig}));
  endtask

  initial begin
    res_t r;
    pat_a = '{4'hA, 4'h5, 4'hF, 4'h3, 4'h7, 4'h0, 4'hF, 4'h9};
    pat_b = '{4'hA, 4'h5, 4'h1, 4'h4, 4'h7, 4'h0, 4'hF, 4'h6};
    pat_c = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    init_n = 1'b0;
    bus.test = 1'b0;
    bus.at = 0; bus.bt = 0; bus.cint = 0; bus.sum = 0; bus.cout = 0;
    step(); step();
    chk("reset_state", 32'({bus.busy, bus.done, bus.pass, bus.err_cnt, bus.err_mask,
                            bus.first_fail, bus.fail_seen, bus.signature}), 32'd0);
    // reset overrides test
    bus.test = 1'b1;
    step();
    chk("reset_over_test", 32'(bus.busy), 32'd0);
    bus.test = 1'b0;
    init_n = 1'b1;
    step();

    // pattern 0 ideal response check against the stated values
    chk("pat0_ideal", 32'(adder(4'hA, 4'hA, 1'b1, 0)), 32'h15);

    session(0, 0, -1, r);
    clean_sig = r.sig;
    chk("clean_pass", 32'(r.pass), 32'd1);

    session(1, 0, -1, r);
    chk("sa0_mask", 32'(r.mask), 32'b00010);
    chk("sa0_ff", 32'(r.ff), 32'd1);

    session(2, 0, -1, r);
    chk("dbl_mask", 32'(r.mask), 32'b11000);
    chk("dbl_sig_differs", 32'(r.sig != clean_sig), 32'd1);

    session(0, 3, -1, r);

    session(1, 0, 5, r);

    session(3, 0, -1, r);
    chk("b2b_cnt3", 32'(r.cnt), 32'd3);
    session(0, 0, -1, r);
    chk("b2b_pass", 32'(r.pass), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
